// File: rtl/wf_ctrl_pkg.sv
// Shared constants and types for the wall-follower speed-loop control blocks.
package wf_ctrl_pkg;

    localparam int RPM_W = 10;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RPM,
        REQ_L,
        GAP,
        REQ_R
    } sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Modulo-N counter with enable and synchronous clear; pulses tc_out on the
// enabled cycle in which the count wraps from N-1 back to 0.
module tick_divider #(
    parameter int N = 4
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear_in,
    input  logic en_in,
    output logic tc_out
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk_in) begin
        if (reset_in || clear_in) begin
            count <= '0;
        end else if (en_in) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign tc_out = en_in && (count == LAST);

endmodule

// File: rtl/wf_speed_sample_scheduler.sv
// Speed-loop sequencer: tach clock enable, 50 ms sample windows, and the
// left-then-right hand-off of captured RPMs to the shared PID engine.
module wf_speed_sample_scheduler #(
    parameter int CLK_DIV      = 12500,
    parameter int WINDOW_TICKS = 500,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int RPM_W        = wf_ctrl_pkg::RPM_W
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             enable_in,
    output logic             clk_en_out,
    output logic             window_done_out,
    input  logic [RPM_W-1:0] rpm_left_in,
    input  logic [RPM_W-1:0] rpm_right_in,
    output logic             pid_req_out,
    output logic             pid_ch_out,
    output logic [RPM_W-1:0] pid_rpm_out,
    input  logic             pid_ack_in,
    output logic             busy_out,
    output logic             overrun_err_out,
    output logic             timeout_err_out,
    input  logic             clear_err_in
);

    import wf_ctrl_pkg::*;

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    sched_state_t     state;
    logic [TW-1:0]    timer;
    logic [RPM_W-1:0] rpm_left_q;
    logic [RPM_W-1:0] rpm_right_q;
    logic             in_req;
    logic             expired;
    logic             req_done;

    // Dropping enable clears both counters so they restart aligned to a fresh window.
    tick_divider #(.N(CLK_DIV)) u_prescaler (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear_in (!enable_in),
        .en_in    (enable_in),
        .tc_out   (clk_en_out)
    );

    tick_divider #(.N(WINDOW_TICKS)) u_window (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear_in (!enable_in),
        .en_in    (clk_en_out),
        .tc_out   (window_done_out)
    );

    assign in_req   = (state == REQ_L) || (state == REQ_R);
    assign expired  = in_req && (timer == TIMER_LAST);
    assign req_done = in_req && (pid_ack_in || expired);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= IDLE;
            timer           <= '0;
            rpm_left_q      <= '0;
            rpm_right_q     <= '0;
            overrun_err_out <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            if (in_req) begin
                timer <= timer + TW'(1);
            end
            case (state)
                IDLE: begin
                    if (window_done_out) state <= WAIT_RPM;
                end
                // Tach RPM settles one cycle after the window edge, so sample here.
                WAIT_RPM: begin
                    rpm_left_q  <= rpm_left_in;
                    rpm_right_q <= rpm_right_in;
                    timer       <= '0;
                    state       <= REQ_L;
                end
                REQ_L: begin
                    if (req_done) state <= GAP;
                end
                GAP: begin
                    timer <= '0;
                    state <= REQ_R;
                end
                REQ_R: begin
                    if (req_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            overrun_err_out <= (window_done_out && (state != IDLE)) ||
                               (overrun_err_out && !clear_err_in);
            timeout_err_out <= (expired && !pid_ack_in) ||
                               (timeout_err_out && !clear_err_in);
        end
    end

    assign busy_out    = (state != IDLE);
    assign pid_req_out = in_req;
    assign pid_ch_out  = (state == REQ_R) ? CH_RIGHT : CH_LEFT;
    assign pid_rpm_out = (state == REQ_L) ? rpm_left_q  :
                         (state == REQ_R) ? rpm_right_q : '0;

endmodule

// File: tb/tb_wf_speed_sample_scheduler.sv
// Scoreboarded bench for wf_speed_sample_scheduler with CLK_DIV=4, WINDOW_TICKS=5.
module tb_wf_speed_sample_scheduler;

    localparam int RW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [RW-1:0] rpm_l = '0;
    logic [RW-1:0] rpm_r = '0;
    logic          ack = 1'b0;
    logic          ack16 = 1'b0;
    logic          clear_err = 1'b0;

    logic          clk_en, wdone, req, ch, busy, ovr, tmo;
    logic [RW-1:0] rpm;
    logic          clk_en16, wdone16, req16, ch16, busy16, ovr16, tmo16;
    logic [RW-1:0] rpm16;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b1;

    typedef struct {
        logic ch;
        int   rpm;
        int   cyc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    wf_speed_sample_scheduler #(.CLK_DIV(4), .WINDOW_TICKS(5), .ACK_TIMEOUT(8), .RPM_W(RW)) dut (
        .clk_in(clk), .reset_in(rst), .enable_in(enable),
        .clk_en_out(clk_en), .window_done_out(wdone),
        .rpm_left_in(rpm_l), .rpm_right_in(rpm_r),
        .pid_req_out(req), .pid_ch_out(ch), .pid_rpm_out(rpm), .pid_ack_in(ack),
        .busy_out(busy), .overrun_err_out(ovr), .timeout_err_out(tmo),
        .clear_err_in(clear_err)
    );

    wf_speed_sample_scheduler #(.CLK_DIV(4), .WINDOW_TICKS(5), .ACK_TIMEOUT(16), .RPM_W(RW)) dut16 (
        .clk_in(clk), .reset_in(rst), .enable_in(enable),
        .clk_en_out(clk_en16), .window_done_out(wdone16),
        .rpm_left_in(rpm_l), .rpm_right_in(rpm_r),
        .pid_req_out(req16), .pid_ch_out(ch16), .pid_rpm_out(rpm16), .pid_ack_in(ack16),
        .busy_out(busy16), .overrun_err_out(ovr16), .timeout_err_out(tmo16),
        .clear_err_in(clear_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic c, input int r, input int at);
        exp_t e;
        e.ch  = c;
        e.rpm = r;
        e.cyc = at;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cyc: reached cycle %0d, expected %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: each rising request pops one expected transfer; held values are checked against it.
    initial begin
        exp_t cur;
        bit   have_cur = 1'b0;
        logic req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (req === 1'b1 && req_prev !== 1'b1) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_req at cycle %0d: ch %0d rpm %0d", cyc, ch, rpm);
                        have_cur = 1'b0;
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1'b1;
                        check("req_start_cycle", cyc, cur.cyc);
                        check("req_ch", ch, cur.ch);
                        check("req_rpm", rpm, cur.rpm);
                    end
                end else if (req === 1'b1 && have_cur) begin
                    check("req_hold_ch", ch, cur.ch);
                    check("req_hold_rpm", rpm, cur.rpm);
                end
            end
            req_prev = req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Free-run timing with ack tied high
        ack   = 1'b1;
        rpm_l = 10'd111;
        rpm_r = 10'd222;
        push(1'b0, 111, 21);
        push(1'b1, 222, 23);
        push(1'b0, 111, 41);
        push(1'b1, 222, 43);
        do_reset();
        check("rst_req", req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_tmo", tmo, 1'b0);
        check("rst_rpm", rpm, 0);
        for (int c = 0; c <= 44; c++) begin
            wait_cyc(c);
            check("clk_en", clk_en, (c % 4) == 3);
            check("window_done", wdone, (c == 19) || (c == 39));
        end
        check("s1_idle_busy", busy, 1'b0);

        // Handshake with ack two cycles after each request rises
        ack   = 1'b0;
        rpm_l = 10'd333;
        rpm_r = 10'd500;
        push(1'b0, 333, 21);
        push(1'b1, 500, 25);
        do_reset();
        wait_cyc(20);
        check("s2_wait_busy", busy, 1'b1);
        check("s2_wait_req", req, 1'b0);
        wait_cyc(23);
        ack = 1'b1;
        wait_cyc(24);
        ack = 1'b0;
        check("s2_gap_req", req, 1'b0);
        check("s2_gap_ch", ch, 1'b0);
        check("s2_gap_rpm", rpm, 0);
        check("s2_gap_busy", busy, 1'b1);
        wait_cyc(27);
        ack = 1'b1;
        wait_cyc(28);
        ack = 1'b0;
        check("s2_done_busy", busy, 1'b0);
        check("s2_done_req", req, 1'b0);
        check("s2_no_tmo", tmo, 1'b0);

        // Timeouts, clear colliding with a timeout, then reset mid-request
        rpm_l = 10'd100;
        rpm_r = 10'd200;
        push(1'b0, 100, 21);
        push(1'b1, 200, 30);
        push(1'b0, 100, 41);
        do_reset();
        wait_cyc(28);
        check("s3_last_req", req, 1'b1);
        check("s3_tmo_before", tmo, 1'b0);
        wait_cyc(29);
        check("s3_tmo_set", tmo, 1'b1);
        check("s3_gap_req", req, 1'b0);
        check("s3_gap_busy", busy, 1'b1);
        wait_cyc(37);
        clear_err = 1'b1;
        wait_cyc(38);
        clear_err = 1'b0;
        check("s6_set_wins", tmo, 1'b1);
        check("s3_idle_busy", busy, 1'b0);
        wait_cyc(42);
        check("s5_pre_req", req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_req", req, 1'b0);
        check("s5_busy", busy, 1'b0);
        check("s5_tmo", tmo, 1'b0);
        check("s5_ovr", ovr, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            wait_cyc(c);
            check("s5_clk_en", clk_en, c == 3);
        end

        // Overrun on the 16-cycle-timeout instance, then enable drop in WAIT_RPM
        mon_en = 1'b0;
        rpm_l  = 10'd400;
        rpm_r  = 10'd600;
        do_reset();
        wait_cyc(38);
        rpm_l = 10'd7;
        rpm_r = 10'd9;
        wait_cyc(39);
        check("s4_wdone39", wdone16, 1'b1);
        check("s4_busy39", busy16, 1'b1);
        check("s4_ovr_before", ovr16, 1'b0);
        wait_cyc(40);
        check("s4_ovr_set", ovr16, 1'b1);
        check("s4_reqr_ch", ch16, 1'b1);
        check("s4_reqr_rpm", rpm16, 600);
        wait_cyc(45);
        rpm_l = 10'd11;
        rpm_r = 10'd13;
        wait_cyc(53);
        check("s4_no_recapture", rpm16, 600);
        wait_cyc(54);
        check("s4_idle_busy", busy16, 1'b0);
        check("s4_tmo", tmo16, 1'b1);
        wait_cyc(59);
        check("s4_wdone59", wdone16, 1'b1);
        wait_cyc(60);
        enable = 1'b0;
        check("s4_wait_busy", busy16, 1'b1);
        check("s4_wait_req", req16, 1'b0);
        wait_cyc(61);
        check("s4_reql_req", req16, 1'b1);
        check("s4_reql_ch", ch16, 1'b0);
        check("s4_reql_rpm", rpm16, 11);
        wait_cyc(63);
        ack16 = 1'b1;
        wait_cyc(64);
        ack16 = 1'b0;
        check("s6_gap_req", req16, 1'b0);
        check("s6_gap_busy", busy16, 1'b1);
        wait_cyc(65);
        check("s6_reqr_ch", ch16, 1'b1);
        check("s6_reqr_rpm", rpm16, 13);
        wait_cyc(66);
        ack16 = 1'b1;
        wait_cyc(67);
        ack16 = 1'b0;
        check("s6_done_busy", busy16, 1'b0);
        clear_err = 1'b1;
        wait_cyc(68);
        clear_err = 1'b0;
        check("s6_clear_ovr", ovr16, 1'b0);
        check("s6_clear_tmo", tmo16, 1'b0);
        for (int c = 68; c <= 80; c++) begin
            wait_cyc(c);
            check("s6_no_clk_en", clk_en16, 1'b0);
        end

        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
